// File: rtl/data_generator.sv
// rtl/data_generator.sv - two-packet 4-phase bundled-data sender with synchronised ack
module data_generator #(
   parameter int                      WIDTH_packet = 14,
   parameter logic [WIDTH_packet-1:0] SENDVALUE1   = 14'b11001011111110,
   parameter logic [WIDTH_packet-1:0] SENDVALUE2   = 14'b10101111111101,
   parameter int                      FL           = 2,
   parameter int                      BL           = 1,
   parameter int                      REPEAT       = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    req,
   output logic [WIDTH_packet-1:0] data,
   input  logic                    ack,
   output logic [1:0]              sent_count,
   output logic                    done
);

   localparam int MAXL = (FL > BL) ? FL : BL;
   localparam int CW   = (MAXL < 2) ? 1 : $clog2(MAXL + 1);
   localparam logic [CW-1:0] FL_C = CW'(FL);
   localparam logic [CW-1:0] BL_C = CW'(BL);

   typedef enum logic [2:0] {
      FL_WAIT = 3'd0,
      REQ_HI  = 3'd1,
      REQ_LO  = 3'd2,
      BL_WAIT = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    idx_q, idx_d;
   logic                    req_q, req_d;
   logic [WIDTH_packet-1:0] data_q, data_d;
   logic [1:0]              sent_q, sent_d;
   logic                    done_q, done_d;
   logic                    ack_meta_q, ack_meta_d;
   logic                    ack_s_q, ack_s_d;

   // ack comes from another clock domain; only ack_s_q may reach the FSM
   always_comb begin
      ack_meta_d = ack;
      ack_s_d    = ack_meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         ack_meta_q <= ack_meta_d;
         ack_s_q    <= ack_s_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FL_WAIT;
         cnt_q   <= '0;
         idx_q   <= 1'b0;
         req_q   <= 1'b0;
         data_q  <= '0;
         sent_q  <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         req_q   <= req_d;
         data_q  <= data_d;
         sent_q  <= sent_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      req_d   = req_q;
      data_d  = data_q;
      sent_d  = sent_q;
      done_d  = done_q;
      case (state_q)
         FL_WAIT: begin
            // once the latency has elapsed the counter parks until the receiver has released ack
            if (cnt_q != FL_C) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!ack_s_q) begin
               req_d   = 1'b1;
               data_d  = idx_q ? SENDVALUE2 : SENDVALUE1;
               cnt_d   = '0;
               state_d = REQ_HI;
            end
         end
         REQ_HI: begin
            if (ack_s_q) begin
               req_d   = 1'b0;
               state_d = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!ack_s_q) begin
               if (sent_q != 2'd3) begin
                  sent_d = sent_q + 2'd1;
               end
               cnt_d   = '0;
               state_d = BL_WAIT;
            end
         end
         BL_WAIT: begin
            if (cnt_q != BL_C) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (!idx_q) begin
                  idx_d   = 1'b1;
                  state_d = FL_WAIT;
               end else if (REPEAT != 0) begin
                  idx_d   = 1'b0;
                  state_d = FL_WAIT;
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = FL_WAIT;
         end
      endcase
   end

   assign req        = req_q;
   assign data       = data_q;
   assign sent_count = sent_q;
   assign done       = done_q;

endmodule

// File: tb/tb_data_generator.sv
// tb/tb_data_generator.sv - directed vector table plus handshake corner sequences for data_generator
module tb_data_generator;

   localparam logic [13:0] P1 = 14'h32FE;
   localparam logic [13:0] P2 = 14'h2BFD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ack_m = 1'b0, ack_f = 1'b0, ack_r = 1'b0;
   logic        req_m, req_f, req_r;
   logic [13:0] data_m, data_f, data_r;
   logic [1:0]  cnt_m, cnt_f, cnt_r;
   logic        done_m, done_f, done_r;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_generator u_main (
      .clk(clk), .reset(rst), .req(req_m), .data(data_m), .ack(ack_m),
      .sent_count(cnt_m), .done(done_m)
   );

   data_generator #(.FL(0), .BL(0)) u_fast (
      .clk(clk), .reset(rst), .req(req_f), .data(data_f), .ack(ack_f),
      .sent_count(cnt_f), .done(done_f)
   );

   data_generator #(.REPEAT(1)) u_rep (
      .clk(clk), .reset(rst), .req(req_r), .data(data_r), .ack(ack_r),
      .sent_count(cnt_r), .done(done_r)
   );

   typedef struct {
      logic        rst;
      logic        ack;
      logic        req;
      logic [13:0] data;
      logic [1:0]  cnt;
      logic        done;
   } vec_t;

   vec_t vt[29];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      ack_m = 1'b0;
      ack_f = 1'b0;
      ack_r = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic edges_to_req_m(input logic lvl, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (req_m !== lvl && n < 40);
   endtask

   task automatic edges_to_cnt_m(input logic [1:0] lvl, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (cnt_m !== lvl && n < 40);
   endtask

   initial begin
      int          n;
      int          cyc;
      logic        prev_f, prev_r, done_seen_r;
      logic [13:0] got_f[$];
      int          at_f[$];
      logic [13:0] got_r[$];

      // {reset, ack} -> {req, data, sent_count, done} after each rising edge
      vt[0]  = '{1'b1, 1'b0, 1'b0, 14'h0, 2'd0, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 14'h0, 2'd0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 14'h0, 2'd0, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b1, P1,    2'd0, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 1'b1, P1,    2'd0, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 1'b1, P1,    2'd0, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 1'b0, P1,    2'd0, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 1'b0, P1,    2'd0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, P1,    2'd0, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, P1,    2'd1, 1'b0};
      vt[10] = '{1'b0, 1'b0, 1'b0, P1,    2'd1, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b0, P1,    2'd1, 1'b0};
      vt[12] = '{1'b0, 1'b0, 1'b0, P1,    2'd1, 1'b0};
      vt[13] = '{1'b0, 1'b0, 1'b0, P1,    2'd1, 1'b0};
      vt[14] = '{1'b0, 1'b0, 1'b1, P2,    2'd1, 1'b0};
      vt[15] = '{1'b0, 1'b1, 1'b1, P2,    2'd1, 1'b0};
      vt[16] = '{1'b0, 1'b1, 1'b1, P2,    2'd1, 1'b0};
      vt[17] = '{1'b0, 1'b1, 1'b0, P2,    2'd1, 1'b0};
      vt[18] = '{1'b0, 1'b0, 1'b0, P2,    2'd1, 1'b0};
      vt[19] = '{1'b0, 1'b0, 1'b0, P2,    2'd1, 1'b0};
      vt[20] = '{1'b0, 1'b0, 1'b0, P2,    2'd2, 1'b0};
      vt[21] = '{1'b0, 1'b0, 1'b0, P2,    2'd2, 1'b0};
      vt[22] = '{1'b0, 1'b0, 1'b0, P2,    2'd2, 1'b1};
      vt[23] = '{1'b0, 1'b0, 1'b0, P2,    2'd2, 1'b1};
      vt[24] = '{1'b0, 1'b1, 1'b0, P2,    2'd2, 1'b1};
      vt[25] = '{1'b0, 1'b1, 1'b0, P2,    2'd2, 1'b1};
      vt[26] = '{1'b0, 1'b1, 1'b0, P2,    2'd2, 1'b1};
      vt[27] = '{1'b0, 1'b1, 1'b0, P2,    2'd2, 1'b1};
      vt[28] = '{1'b0, 1'b0, 1'b0, P2,    2'd2, 1'b1};

      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         rst   = vt[i].rst;
         ack_m = vt[i].ack;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_req", i),  32'(req_m),  32'(vt[i].req));
         chk($sformatf("vec%0d_data", i), 32'(data_m), 32'(vt[i].data));
         chk($sformatf("vec%0d_cnt", i),  32'(cnt_m),  32'(vt[i].cnt));
         chk($sformatf("vec%0d_done", i), 32'(done_m), 32'(vt[i].done));
      end

      // slow receiver: ack held low for 20 cycles
      do_reset();
      edges_to_req_m(1'b1, n);
      chk("slow_first_req_edges", 32'(n), 32'd3);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("slow_hold%0d", i), {17'd0, req_m, data_m}, {17'd0, 1'b1, P1});
      end
      @(negedge clk);
      ack_m = 1'b1;
      edges_to_req_m(1'b0, n);
      chk("req_fall_latency", 32'(n), 32'd3);
      @(negedge clk);
      ack_m = 1'b0;
      edges_to_cnt_m(2'd1, n);
      chk("count_latency", 32'(n), 32'd3);

      // premature ack during BL_WAIT stalls the next request and is not counted
      @(negedge clk);
      ack_m = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("premature%0d", i), {29'd0, req_m, cnt_m}, {29'd0, 1'b0, 2'd1});
      end
      @(negedge clk);
      ack_m = 1'b0;
      edges_to_req_m(1'b1, n);
      chk("stall_release_edges", 32'(n), 32'd3);
      chk("second_packet", 32'(data_m), 32'(P2));

      // reset while req is high in the second handshake
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_req", 32'(req_m), 32'd0);
      chk("rst_mid_cnt", 32'(cnt_m), 32'd0);
      chk("rst_mid_data", 32'(data_m), 32'd0);
      chk("rst_mid_done", 32'(done_m), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      edges_to_req_m(1'b1, n);
      chk("restart_edges", 32'(n), 32'd3);
      chk("restart_packet", 32'(data_m), 32'(P1));

      // ack held high across reset release
      @(negedge clk);
      rst   = 1'b1;
      ack_m = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ack_hi_hold%0d", i), 32'(req_m), 32'd0);
      end
      @(negedge clk);
      ack_m = 1'b0;
      edges_to_req_m(1'b1, n);
      chk("ack_hi_release_edges", 32'(n), 32'd3);
      chk("ack_hi_packet", 32'(data_m), 32'(P1));

      // ideal receivers on the FL=0/BL=0 and REPEAT instances
      do_reset();
      prev_f      = 1'b0;
      prev_r      = 1'b0;
      done_seen_r = 1'b0;
      cyc         = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (req_f && !prev_f) begin
            got_f.push_back(data_f);
            at_f.push_back(cyc);
         end
         if (req_r && !prev_r) got_r.push_back(data_r);
         if (done_r) done_seen_r = 1'b1;
         prev_f = req_f;
         prev_r = req_r;
         @(negedge clk);
         ack_f = req_f;
         ack_r = req_r;
      end
      chk("fast_handshakes", 32'(got_f.size()), 32'd2);
      if (got_f.size() >= 2) begin
         chk("fast_first_edge", 32'(at_f[0]), 32'd1);
         chk("fast_second_edge", 32'(at_f[1]), 32'd9);
         chk("fast_pkt0", 32'(got_f[0]), 32'(P1));
         chk("fast_pkt1", 32'(got_f[1]), 32'(P2));
      end
      chk("fast_end", {27'd0, req_f, cnt_f, done_f, 1'b0}, {27'd0, 1'b0, 2'd2, 1'b1, 1'b0});
      chk("fast_end_data", 32'(data_f), 32'(P2));
      chk("rep_enough", 32'(got_r.size() >= 6), 32'd1);
      for (int i = 0; i < 6 && i < got_r.size(); i++) begin
         chk($sformatf("rep_pkt%0d", i), 32'(got_r[i]), (i % 2 == 0) ? 32'(P1) : 32'(P2));
      end
      chk("rep_saturate", 32'(cnt_r), 32'd3);
      chk("rep_no_done", 32'(done_seen_r), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
